reset_board_ctrl: RTL and testbench

- FSM that sequences the reset-board datapath: address load, ROM wait, data capture, board-RAM write, address increment.
- Copies the initial maze (768 cells, addresses 0..767) from the ROM image into the board RAM.
- Arbitrates the board-RAM write port between this copy engine and game logic (pellet eating).
- Sits between the top-level game FSM (start/done) and the datapath plus board RAM.

---
 rtl/reset_board_ctrl_pkg.sv | 17 +
 rtl/reset_board_ctrl_if.sv | 51 +++++
 rtl/reset_board_ctrl.sv | 75 +++++++
 tb/tb_reset_board_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_board_ctrl_pkg.sv
// Shared types for the reset-board copy controller.
// States and board geometry used by the controller and its datapath.
package reset_board_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        FETCH,
        WRITE,
        DONE
    } rb_state_t;

    localparam int         BOARD_CELLS     = 768;
    localparam logic [9:0] BOARD_LAST_ADDR = 10'd767;

endpackage

// File: rtl/reset_board_ctrl_if.sv
// Control bundle between game FSM, datapath and the copy controller.
// RESET_BOARD_ABORT_EN adds the abort request line.
interface reset_board_ctrl_if;

    logic start;
    logic game_req;
    logic last_addr_reached;
`ifdef RESET_BOARD_ABORT_EN
    logic abort;
`endif
    logic load;
    logic get_data;
    logic incr;
    logic board_we;
    logic game_grant;
    logic busy;
    logic done;

    modport master (
`ifdef RESET_BOARD_ABORT_EN
        input  abort,
`endif
        input  start,
        input  game_req,
        input  last_addr_reached,
        output load,
        output get_data,
        output incr,
        output board_we,
        output game_grant,
        output busy,
        output done
    );

    modport slave (
`ifdef RESET_BOARD_ABORT_EN
        output abort,
`endif
        output start,
        output game_req,
        output last_addr_reached,
        input  load,
        input  get_data,
        input  incr,
        input  board_we,
        input  game_grant,
        input  busy,
        input  done
    );

endinterface

// File: rtl/reset_board_ctrl.sv
// Sequences the ROM-to-board-RAM copy and arbitrates the RAM write port.
// RESET_BOARD_ABORT_EN enables an abort request that cancels a running copy.
module reset_board_ctrl
    import reset_board_pkg::*;
#(
    parameter int ROM_LATENCY = 1,
    parameter bit AUTO_START  = 1'b1
) (
    input logic               clk,
    input logic               reset,
    reset_board_ctrl_if.master bus
);

    localparam int CW = $clog2(ROM_LATENCY + 1);

    rb_state_t         r_state;
    rb_state_t         w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_auto;
    logic              r_done;
    logic              r_grant;
    logic              w_abort;
    logic              w_wr;

`ifdef RESET_BOARD_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start || r_auto) w_next = LOAD;
            LOAD:    w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = FETCH;
            FETCH:   w_next = WRITE;
            WRITE:   w_next = bus.last_addr_reached ? DONE : WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort && r_state != IDLE) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_auto  <= AUTO_START;
            r_done  <= 1'b0;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next != IDLE) r_auto <= 1'b0;
            // Reload on every entry to WAIT so each cell waits a full ROM latency
            if (w_next == WAIT && r_state != WAIT)
                r_cnt <= CW'(ROM_LATENCY - 1);
            else if (r_state == WAIT && r_cnt != '0)
                r_cnt <= r_cnt - CW'(1);
            r_done  <= (r_state == DONE) && !w_abort;
            r_grant <= (w_next == IDLE) && bus.game_req;
        end
    end

    // An abort landing on WRITE suppresses the write and the increment
    assign w_wr           = (r_state == WRITE) && !w_abort;
    assign bus.load       = (r_state == LOAD);
    assign bus.get_data   = (r_state == FETCH);
    assign bus.board_we   = w_wr;
    assign bus.incr       = w_wr && !bus.last_addr_reached;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.game_grant = r_grant;

endmodule

// File: tb/tb_reset_board_ctrl.sv
// Bench for reset_board_ctrl: two configurations, datapath stand-ins and a cycle model.
// RESET_BOARD_ABORT_EN also exercises the abort request.
module tb_reset_board_ctrl;
    import reset_board_pkg::*;

    localparam int LA = 1;
    localparam int LB = 3;
    localparam int NA = 2 + BOARD_CELLS * (LA + 2);
    localparam int NB = 2 + BOARD_CELLS * (LB + 2);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic st_a = 1'b0, st_b = 1'b0;
    logic gr_a = 1'b0, gr_b = 1'b0;
    logic ab_a = 1'b0, ab_b = 1'b0;

    reset_board_ctrl_if ifa ();
    reset_board_ctrl_if ifb ();

    reset_board_ctrl #(.ROM_LATENCY(LA), .AUTO_START(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.master));
    reset_board_ctrl #(.ROM_LATENCY(LB), .AUTO_START(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.master));

    assign ifa.start    = st_a;
    assign ifa.game_req = gr_a;
    assign ifb.start    = st_b;
    assign ifb.game_req = gr_b;
`ifdef RESET_BOARD_ABORT_EN
    assign ifa.abort = ab_a;
    assign ifb.abort = ab_b;
`endif

    function automatic logic [7:0] rom(input logic [9:0] a);
        int v;
        v = int'(a) * 37 + 5;
        return v[7:0];
    endfunction

    // Datapath + ROM stand-ins
    logic [9:0] adr_a, adr_b;
    logic [7:0] q_a, dat_a, q1_b, q2_b, q3_b, dat_b;
    int cell_a, cell_b;
    int we_a = 0, we_b = 0, dn_a = 0, dn_b = 0, bad_a = 0, bad_b = 0;

    assign ifa.last_addr_reached = (adr_a == BOARD_LAST_ADDR);
    assign ifb.last_addr_reached = (adr_b == BOARD_LAST_ADDR);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            adr_a <= '0; q_a <= '0; dat_a <= '0; cell_a <= 0;
            adr_b <= '0; q1_b <= '0; q2_b <= '0; q3_b <= '0;
            dat_b <= '0; cell_b <= 0;
        end else begin
            q_a <= rom(adr_a);
            if (ifa.load) adr_a <= '0;
            else if (ifa.incr) adr_a <= adr_a + 10'd1;
            if (ifa.get_data) dat_a <= q_a;
            if (ifa.load) cell_a <= 0;
            else if (ifa.board_we) cell_a <= cell_a + 1;
            q1_b <= rom(adr_b); q2_b <= q1_b; q3_b <= q2_b;
            if (ifb.load) adr_b <= '0;
            else if (ifb.incr) adr_b <= adr_b + 10'd1;
            if (ifb.get_data) dat_b <= q3_b;
            if (ifb.load) cell_b <= 0;
            else if (ifb.board_we) cell_b <= cell_b + 1;
        end
    end

    always @(posedge clk) begin
        if (ifa.board_we) begin
            we_a <= we_a + 1;
            if (adr_a != 10'(cell_a) || dat_a != rom(adr_a)) bad_a <= bad_a + 1;
        end
        if (ifb.board_we) begin
            we_b <= we_b + 1;
            if (adr_b != 10'(cell_b) || dat_b != rom(adr_b)) bad_b <= bad_b + 1;
        end
        if (ifa.done) dn_a <= dn_a + 1;
        if (ifb.done) dn_b <= dn_b + 1;
    end

    // Model: a copy is a timeline indexed by k = edges since the start edge
    logic ma_act = 0, ma_auto = 1, ma_done = 0, ma_grant = 0, na_a;
    logic mb_act = 0, mb_auto = 0, mb_done = 0, mb_grant = 0, na_b;
    int   ma_k = 0, mb_k = 0;

    always_comb begin
        na_a = ma_act ? !(ab_a || ma_k == NA) : (st_a || ma_auto);
        na_b = mb_act ? !(ab_b || mb_k == NB) : (st_b || mb_auto);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma_act <= 0; ma_k <= 0; ma_auto <= 1; ma_done <= 0; ma_grant <= 0;
            mb_act <= 0; mb_k <= 0; mb_auto <= 0; mb_done <= 0; mb_grant <= 0;
        end else begin
            ma_act   <= na_a;
            ma_k     <= ma_act ? ma_k + 1 : 1;
            if (!ma_act && na_a) ma_auto <= 0;
            ma_done  <= ma_act && ma_k == NA && !ab_a;
            ma_grant <= gr_a && !na_a;
            mb_act   <= na_b;
            mb_k     <= mb_act ? mb_k + 1 : 1;
            if (!mb_act && na_b) mb_auto <= 0;
            mb_done  <= mb_act && mb_k == NB && !ab_b;
            mb_grant <= gr_b && !na_b;
        end
    end

    // {load, get_data, incr, board_we, busy}
    function automatic logic [4:0] expv(input logic act, input int k,
                                        input int L, input logic ab);
        logic [4:0] v;
        int n, j, c, p;
        v = '0;
        n = 2 + BOARD_CELLS * (L + 2);
        if (act) begin
            v[0] = 1'b1;
            if (k == 1) v[4] = 1'b1;
            else if (k >= 2 && k < n) begin
                j = k - 2;
                c = j / (L + 2);
                p = j % (L + 2);
                v[3] = (p == L);
                if (p == L + 1 && !ab) begin
                    v[1] = 1'b1;
                    v[2] = (c != BOARD_CELLS - 1);
                end
            end
        end
        return v;
    endfunction

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] vec_a();
        return {ifa.load, ifa.get_data, ifa.incr, ifa.board_we,
                ifa.busy, ifa.done, ifa.game_grant};
    endfunction

    function automatic logic [6:0] vec_b();
        return {ifb.load, ifb.get_data, ifb.incr, ifb.board_we,
                ifb.busy, ifb.done, ifb.game_grant};
    endfunction

    task automatic tick();
        @(negedge clk);
        chk("cyc_a", 32'(vec_a()), 32'({expv(ma_act, ma_k, LA, ab_a), ma_done, ma_grant}));
        chk("cyc_b", 32'(vec_b()), 32'({expv(mb_act, mb_k, LB, ab_b), mb_done, mb_grant}));
        @(posedge clk);
        #2;
    endtask

    int t0, base, n, g1, g2, dbase;
    logic pulsed;

    initial begin
        gr_b = 1'b1;
        repeat (3) tick();
        chk("rst_a", 32'(vec_a()), 0);
        chk("rst_b", 32'(vec_b()), 0);

        // Power-up auto copy with a stray start at cell 100
        reset = 1'b1;
        base = we_a;
        tick();
        t0 = cyc;
        chk("busy_after_release", 32'(ifa.busy), 1);
        pulsed = 0;
        n = 0;
        while (!ifa.done && n < 3000) begin
            st_a = !pulsed && (we_a - base == 100);
            if (st_a) pulsed = 1;
            tick();
            n++;
        end
        st_a = 1'b0;
        chk("done_seen_a", 32'(ifa.done), 1);
        chk("lat_a", 32'(cyc - t0), 2306);
        repeat (3) tick();
        chk("we_cnt_a", 32'(we_a - base), 768);
        chk("done_cnt_a", 32'(dn_a), 1);
        chk("data_a", 32'(bad_a), 0);

        // Reset in the middle of a copy, then auto restart
        base = we_a;
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        n = 0;
        while (we_a - base < 300 && n < 1500) begin tick(); n++; end
        chk("reach300_a", 32'(we_a - base), 300);
        reset = 1'b0;
        #1;
        chk("async_rst_a", 32'(vec_a()), 0);
        dbase = dn_a;
        repeat (3) tick();
        reset = 1'b1;
        base = we_a;
        tick();
        t0 = cyc;
        n = 0;
        while (!ifa.done && n < 3000) begin tick(); n++; end
        chk("lat_restart_a", 32'(cyc - t0), 2306);
        repeat (2) tick();
        chk("we_restart_a", 32'(we_a - base), 768);
        chk("done_restart_a", 32'(dn_a - dbase), 1);
        chk("data_restart_a", 32'(bad_a), 0);

        // Start against a pending game request, ROM latency 3
        chk("grant_idle_b", 32'(ifb.game_grant), 1);
        base = we_b;
        st_b = 1'b1;
        tick();
        st_b = 1'b0;
        t0 = cyc;
        chk("grant_drop_b", 32'(ifb.game_grant), 0);
        g1 = 0;
        g2 = 0;
        n = 0;
        while (!ifb.done && n < 5000) begin
            tick();
            if (ifb.get_data && g1 == 0) g1 = cyc;
            else if (ifb.get_data && g2 == 0) g2 = cyc;
            n++;
        end
        chk("lat_b", 32'(cyc - t0), 3842);
        chk("get_gap_b", 32'(g2 - g1), 5);
        chk("grant_back_b", 32'(ifb.game_grant), 1);
        repeat (2) tick();
        chk("we_cnt_b", 32'(we_b - base), 768);
        chk("done_cnt_b", 32'(dn_b), 1);
        chk("data_b", 32'(bad_b), 0);

`ifdef RESET_BOARD_ABORT_EN
        base = we_a;
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        n = 0;
        while (we_a - base < 50 && n < 500) begin tick(); n++; end
        dbase = dn_a;
        ab_a = 1'b1;
        st_a = 1'b1;
        tick();
        ab_a = 1'b0;
        st_a = 1'b0;
        chk("abort_idle_a", 32'(ifa.busy), 0);
        chk("abort_we_a", 32'((we_a - base == 50) || (we_a - base == 51)), 1);
        repeat (5) tick();
        chk("abort_stay_idle_a", 32'(ifa.busy), 0);
        chk("abort_no_done_a", 32'(dn_a - dbase), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
